// File: rtl/game_timer_pkg.sv
// Shared types and default sizing for the game timer.
package game_timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_CLK_DIV = 100000000;
  localparam int unsigned DEF_TIME_W  = 8;

endpackage

// File: rtl/game_timer_prescaler.sv
// Free-running clk-to-game-second prescaler; tc pulses on the enabled wrap cycle.
module tick_prescaler
  import game_timer_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign tc     = en && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_timer.sv
// Game timer: counts game seconds up (optional limit) or down to zero.
//   state   | meaning
//   IDLE    | waiting for start
//   RUN     | prescaler advancing, elapsed updates on each wrap
//   PAUSE   | prescaler and elapsed frozen while pause is high
//   DONE    | limit or zero reached, elapsed holds final value
module game_timer
  import game_timer_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned TIME_W  = DEF_TIME_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              clear,
  input  logic              mode_down,
  input  logic [TIME_W-1:0] load_val,
  output logic              tick,
  output logic [TIME_W-1:0] elapsed,
  output logic              timeout,
  output logic              running,
  output logic              done
);

  state_t            r_state;
  logic              r_mode_down;
  logic [TIME_W-1:0] r_limit;
  logic [TIME_W-1:0] r_elapsed;
  logic              r_tick;
  logic              r_timeout;
  logic              r_running;
  logic              r_done;

  logic              w_start_ok;
  logic              w_presc_en;
  logic              w_presc_clr;
  logic              w_tc;
  logic [TIME_W-1:0] w_elapsed_nxt;
  logic              w_hit_end;

  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  // pause wins on the terminal cycle, so it also gates the prescaler
  assign w_presc_en  = (r_state == S_RUN) && !pause;
  assign w_presc_clr = clear || w_start_ok;

  assign w_elapsed_nxt = r_mode_down ? (r_elapsed - 1'b1) : (r_elapsed + 1'b1);
  assign w_hit_end     = r_mode_down ? (w_elapsed_nxt == '0)
                                     : ((r_limit != '0) && (w_elapsed_nxt == r_limit));

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_presc_en),
    .clr   (w_presc_clr),
    .tc    (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mode_down <= 1'b0;
      r_limit     <= '0;
      r_elapsed   <= '0;
      r_tick      <= 1'b0;
      r_timeout   <= 1'b0;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_tick    <= 1'b0;
      r_timeout <= 1'b0;
      if (clear) begin
        r_state   <= S_IDLE;
        r_elapsed <= '0;
        r_running <= 1'b0;
        r_done    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_mode_down <= mode_down;
              r_limit     <= load_val;
              if (mode_down && (load_val == '0)) begin
                r_state   <= S_DONE;
                r_elapsed <= '0;
                r_timeout <= 1'b1;
                r_running <= 1'b0;
                r_done    <= 1'b1;
              end else begin
                r_state   <= S_RUN;
                r_elapsed <= mode_down ? load_val : '0;
                r_running <= 1'b1;
                r_done    <= 1'b0;
              end
            end
          end
          S_RUN: begin
            if (pause) begin
              r_state   <= S_PAUSE;
              r_running <= 1'b0;
            end else if (w_tc) begin
              r_tick    <= 1'b1;
              r_elapsed <= w_elapsed_nxt;
              if (w_hit_end) begin
                r_state   <= S_DONE;
                r_timeout <= 1'b1;
                r_running <= 1'b0;
                r_done    <= 1'b1;
              end
            end
          end
          S_PAUSE: begin
            if (!pause) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tick    = r_tick;
  assign elapsed = r_elapsed;
  assign timeout = r_timeout;
  assign running = r_running;
  assign done    = r_done;

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer at CLK_DIV=4, TIME_W=8.
module tb_game_timer;

  localparam int DIV = 4;
  localparam int TW  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          clear = 1'b0;
  logic          mode_down = 1'b0;
  logic [TW-1:0] load_val = '0;
  logic          tick, timeout, running, done;
  logic [TW-1:0] elapsed;

  int checks = 0;
  int errors = 0;

  game_timer #(.CLK_DIV(DIV), .TIME_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pause     (pause),
    .clear     (clear),
    .mode_down (mode_down),
    .load_val  (load_val),
    .tick      (tick),
    .elapsed   (elapsed),
    .timeout   (timeout),
    .running   (running),
    .done      (done)
  );

  always #5 clk = ~clk;

  // packed as {tick, elapsed, timeout, running, done}
  function automatic logic [11:0] pk(bit t, int e, bit to, bit r, bit d);
    logic [7:0] e8;
    e8 = e[7:0];
    return {t, e8, to, r, d};
  endfunction

  task automatic chk(input string nm, input logic [11:0] exp);
    logic [11:0] got;
    got = {tick, elapsed, timeout, running, done};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got tick=%b el=%0d to=%b run=%b done=%b exp tick=%b el=%0d to=%b run=%b done=%b",
               nm, got[11], got[10:3], got[2], got[1], got[0],
               exp[11], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input bit st, input bit pa, input bit cl, input bit md, input int lv);
    start = st; pause = pa; clear = cl; mode_down = md; load_val = lv[7:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    drive(0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  typedef struct {
    bit          st, pa, cl, md;
    int          lv;
    int          n;
    logic [11:0] exp;
    string       nm;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit st, input bit pa, input bit cl, input bit md, input int lv,
                     input int n, input logic [11:0] exp, input string nm);
    vec_t v;
    v.st = st; v.pa = pa; v.cl = cl; v.md = md; v.lv = lv; v.n = n; v.exp = exp; v.nm = nm;
    tbl.push_back(v);
  endtask

  // Behavioural reference: plain counters for seconds phase and time value.
  bit m_active, m_frozen, m_finished, m_down, m_tick, m_to;
  int m_lim, m_phase, m_time;

  task automatic model_step(input bit st, input bit pa, input bit cl, input bit md, input int lv);
    m_tick = 0; m_to = 0;
    if (cl) begin
      m_active = 0; m_frozen = 0; m_finished = 0; m_phase = 0; m_time = 0;
    end else if (!m_active && st) begin
      m_down = md; m_lim = lv; m_phase = 0; m_frozen = 0;
      if (md && lv == 0) begin
        m_finished = 1; m_active = 0; m_time = 0; m_to = 1;
      end else begin
        m_finished = 0; m_active = 1; m_time = md ? lv : 0;
      end
    end else if (m_active && !m_frozen) begin
      if (pa) m_frozen = 1;
      else if (m_phase == DIV - 1) begin
        m_phase = 0;
        m_tick  = 1;
        m_time  = m_down ? m_time - 1 : (m_time + 1) % 256;
        if (m_down ? (m_time == 0) : (m_lim != 0 && m_time == m_lim)) begin
          m_active = 0; m_finished = 1; m_to = 1;
        end
      end else m_phase++;
    end else if (m_active && m_frozen) begin
      if (!pa) m_frozen = 0;
    end
  endtask

  initial begin
    bit rpause;
    #2;
    chk("reset_hold", pk(0, 0, 0, 0, 0));
    start = 1'b1;
    #10;
    chk("reset_ignores_start", pk(0, 0, 0, 0, 0));
    start = 1'b0;
    step();
    rst_n = 1'b1;

    // up limit 3
    add(1, 0, 0, 0, 3, 1, pk(0, 0, 0, 1, 0), "up_accept");
    add(0, 0, 0, 0, 0, 3, pk(0, 0, 0, 1, 0), "up_pre_tick");
    add(0, 0, 0, 0, 0, 1, pk(1, 1, 0, 1, 0), "up_tick1");
    add(0, 0, 0, 0, 0, 4, pk(1, 2, 0, 1, 0), "up_tick2");
    add(0, 0, 0, 0, 0, 4, pk(1, 3, 1, 0, 1), "up_limit_done");
    add(0, 0, 0, 0, 0, 1, pk(0, 3, 0, 0, 1), "up_done_hold1");
    add(0, 0, 0, 0, 0, 5, pk(0, 3, 0, 0, 1), "up_done_hold5");
    // down from DONE
    add(1, 0, 0, 1, 2, 1, pk(0, 2, 0, 1, 0), "dn_accept");
    add(0, 0, 0, 0, 0, 4, pk(1, 1, 0, 1, 0), "dn_tick1");
    add(0, 0, 0, 0, 0, 4, pk(1, 0, 1, 0, 1), "dn_zero_done");
    add(1, 0, 0, 1, 0, 1, pk(0, 0, 1, 0, 1), "dn_load0_done");
    add(0, 0, 0, 0, 0, 1, pk(0, 0, 0, 0, 1), "dn_load0_hold");
    // repeated start in RUN, then clear
    add(1, 0, 0, 0, 0, 1, pk(0, 0, 0, 1, 0), "free_accept");
    add(1, 0, 0, 1, 9, 2, pk(0, 0, 0, 1, 0), "restart_ignored");
    add(0, 0, 0, 0, 0, 2, pk(1, 1, 0, 1, 0), "restart_no_relatch");
    add(1, 0, 0, 1, 9, 3, pk(0, 1, 0, 1, 0), "restart_ignored2");
    add(0, 0, 0, 0, 0, 1, pk(1, 2, 0, 1, 0), "free_tick2");
    add(0, 0, 1, 0, 0, 1, pk(0, 0, 0, 0, 0), "clear_run");
    add(0, 0, 0, 0, 0, 6, pk(0, 0, 0, 0, 0), "idle_wait");
    add(1, 0, 1, 0, 5, 1, pk(0, 0, 0, 0, 0), "clear_beats_start");
    add(1, 0, 0, 1, 0, 1, pk(0, 0, 1, 0, 1), "done_again");
    add(0, 0, 1, 0, 0, 1, pk(0, 0, 0, 0, 0), "clear_done");

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].pa, tbl[i].cl, tbl[i].md, tbl[i].lv);
      repeat (tbl[i].n) step();
      chk(tbl[i].nm, tbl[i].exp);
    end

    // free-run wrap 255 -> 0
    drive(1, 0, 0, 0, 0); step();
    cyc(1019);
    step();
    chk("wrap_255", pk(1, 255, 0, 1, 0));
    cyc(3); step();
    chk("wrap_0_no_timeout", pk(1, 0, 0, 1, 0));

    // pause on terminal cycle
    drive(0, 0, 1, 0, 0); step();
    drive(1, 0, 0, 0, 0); step();
    cyc(3);
    chk("pause_pre", pk(0, 0, 0, 1, 0));
    drive(0, 1, 0, 0, 0); step();
    chk("pause_terminal_no_tick", pk(0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      step();
      chk("pause_held", pk(0, 0, 0, 0, 0));
    end
    drive(0, 0, 0, 0, 0); step();
    chk("pause_release", pk(0, 0, 0, 1, 0));
    step();
    chk("pause_resume_tick", pk(1, 1, 0, 1, 0));
    cyc(3);
    chk("pause_after_gap", pk(0, 1, 0, 1, 0));
    step();
    chk("pause_next_tick", pk(1, 2, 0, 1, 0));

    // async reset mid-RUN
    drive(0, 0, 1, 0, 0); step();
    drive(1, 0, 0, 0, 0); step();
    cyc(6);
    chk("rst_pre", pk(0, 1, 0, 1, 0));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_immediate", pk(0, 0, 0, 0, 0));
    step(); step();
    chk("rst_held", pk(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    step();
    chk("rst_idle_after", pk(0, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 0); step();
    chk("rst_restart", pk(0, 0, 0, 1, 0));
    cyc(3);
    chk("rst_no_early_tick", pk(0, 0, 0, 1, 0));
    step();
    chk("rst_first_tick", pk(1, 1, 0, 1, 0));

    // randomized against the reference model
    m_active = 0; m_frozen = 0; m_finished = 0; m_down = 0;
    m_lim = 0; m_phase = 0; m_time = 0;
    rpause = 0;
    for (int i = 0; i < 3000; i++) begin
      bit st, cl, md;
      int lv;
      cl = (i == 0) || ($urandom_range(59) == 0);
      st = ($urandom_range(7) == 0);
      if ($urandom_range(9) == 0) rpause = ~rpause;
      md = $urandom_range(1) == 1;
      lv = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(4));
      drive(st, rpause, cl, md, lv);
      step();
      model_step(st, rpause, cl, md, lv);
      chk("random", pk(m_tick, m_time, m_to, m_active && !m_frozen, m_finished));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
